stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_if.sv | 36 +++
 rtl/stopwatch_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl_if
// Purpose  : Groups the stopwatch controller's button inputs and the
//            datapath/display control outputs into one bundle.
// Signals  : btnu     - raw start/stop button (asynchronous)
//            btnd     - raw lap/clear button (asynchronous)
//            tick_en  - one-cycle count-enable pulse to the timer datapath
//            clr      - one-cycle clear pulse to the timer datapath
//            disp_sel - 0 = live digits, 1 = frozen lap digits
//            blank    - per-digit blank mask for the display controller
//            state    - IDLE=00, RUN=01, LAP=10, STOP=11
// Modports : master - button source / control consumer (board, bench)
//            slave  - the stopwatch controller itself
// Revision : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
  logic       btnu;
  logic       btnd;
  logic       tick_en;
  logic       clr;
  logic       disp_sel;
  logic [3:0] blank;
  logic [1:0] state;

  modport master (
    output btnu, btnd,
    input  tick_en, clr, disp_sel, blank, state
  );

  modport slave (
    input  btnu, btnd,
    output tick_en, clr, disp_sel, blank, state
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Stopwatch control: synchronizes and debounces the start/stop and
//            lap/clear buttons, runs the IDLE/RUN/LAP/STOP state machine and
//            generates the count tick, clear pulse and display controls.
// Ports    : clk  - system clock, rising edge
//            btnc - synchronous active-high reset
//            bus  - stopwatch_ctrl_if.slave (buttons in, controls out)
// Params   : TICK_DIV  - clock cycles per count tick
//            DB_CYCLES - consecutive equal samples for a stable button level
//            BLINK_DIV - clock cycles per blank toggle while stopped
// Options  : define STOPWATCH_BLINK_EN to blink the display while in STOP;
//            without it blank is tied to 4'b0000 and no blink counter exists.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 1000000,
  parameter int DB_CYCLES = 1000000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic            clk,
  input  logic            btnc,
  stopwatch_ctrl_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } state_t;

  // --------------------------------------------------------------------------
  // Button conditioning: bit 0 = start/stop (btnu), bit 1 = lap/clear (btnd)
  // --------------------------------------------------------------------------
  logic [1:0] w_raw;
  logic [1:0] w_ev;

  assign w_raw = {bus.btnd, bus.btnu};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_sync1;
      logic            r_sync2;
      logic            r_stable;
      logic            r_ev;
      logic [DB_W-1:0] r_cnt;

      // The counter only advances while the synchronized sample disagrees
      // with the stable level, so any bounce back restarts the run. The
      // event fires on the edge where the stable level flips to 1, which
      // makes a held button produce exactly one event and a release none.
      always_ff @(posedge clk) begin
        if (btnc) begin
          r_sync1  <= 1'b0;
          r_sync2  <= 1'b0;
          r_stable <= 1'b0;
          r_ev     <= 1'b0;
          r_cnt    <= '0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          r_ev    <= 1'b0;
          if (r_sync2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
            r_ev     <= r_sync2;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
      end

      assign w_ev[gi] = r_ev;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_next;
  logic   w_clr;
  logic   w_ev_ss;
  logic   w_ev_lap;

  assign w_ev_ss  = w_ev[0];
  assign w_ev_lap = w_ev[1];

  always_ff @(posedge clk) begin
    if (btnc) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // start/stop is tested first everywhere so it wins over a coincident lap.
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ev_ss) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_ev_ss)       w_state_next = ST_STOP;
        else if (w_ev_lap) w_state_next = ST_LAP;
      end
      ST_LAP: begin
        if (w_ev_ss)       w_state_next = ST_STOP;
        else if (w_ev_lap) w_state_next = ST_RUN;
      end
      ST_STOP: begin
        if (w_ev_ss) begin
          w_state_next = ST_RUN;
        end else if (w_ev_lap) begin
          w_state_next = ST_IDLE;
          w_clr        = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Tick prescaler: counts in RUN/LAP, holds in STOP, zero whenever the next
  // state is IDLE. The tick depends only on the current state, so a stop
  // request in the tick cycle still lets that tick out.
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0] r_presc;
  logic              w_counting;
  logic              w_tick;

  assign w_counting = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_tick     = w_counting && (r_presc == TICK_LAST);

  always_ff @(posedge clk) begin
    if (btnc || (w_state_next == ST_IDLE)) begin
      r_presc <= '0;
    end else if (w_counting) begin
      r_presc <= w_tick ? '0 : (r_presc + TICK_W'(1));
    end
  end

  // --------------------------------------------------------------------------
  // Display blanking
  // --------------------------------------------------------------------------
`ifdef STOPWATCH_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blank;

  // Cleared whenever the next state is not STOP, so STOP is always entered
  // unblanked with the counter at 0 and leaving STOP unblanks immediately.
  always_ff @(posedge clk) begin
    if (btnc || (w_state_next != ST_STOP)) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (r_state == ST_STOP) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blank     <= ~r_blank;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign bus.blank = {4{r_blank}};
`else
  // Blinking compiled out: the display is never blanked.
  assign bus.blank = {4{1'b0 & (BLINK_DIV == 0)}};
`endif

  assign bus.tick_en  = w_tick;
  assign bus.clr      = w_clr;
  assign bus.disp_sel = (r_state == ST_LAP);
  assign bus.state    = r_state;

endmodule
`default_nettype wire
